// File: rtl/aes_cmd_pkg.sv
// Shared constants and FSM state type for the aescipher command driver.
package aes_cmd_pkg;

    localparam logic [1:0] CMD_ID = 2'b00;
    localparam logic [1:0] CMD_ST = 2'b01;
    localparam logic [1:0] CMD_SK = 2'b10;
    localparam logic [1:0] CMD_SP = 2'b11;

    localparam int unsigned BYTES_PER_BLOCK = 16;

    typedef enum logic [3:0] {
        StIdle,
        StSpHdr,
        StSpData,
        StGap1,
        StSkHdr,
        StSkData,
        StGap2,
        StSt,
        StWaitOk,
        StCapture,
        StResp
    } state_e;

endpackage

// File: rtl/aes_cmd_driver_if.sv
// Request/response port plus byte-serial cipher bus of the aescipher command driver.
interface aes_cmd_driver_if;

    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_pt;
    logic [127:0] req_key;
    logic         req_load_key;
    logic         resp_valid;
    logic [127:0] resp_ct;
    logic         resp_timeout;
    logic         busy;
    logic [1:0]   cmd;
    logic [7:0]   din;
    logic         c_ok;
    logic         c_ready;
    logic [7:0]   c_dout;

    // master: the driver, which masters the cipher bus and serves the host request port
    modport master (
        input  req_valid, req_pt, req_key, req_load_key, c_ok, c_ready, c_dout,
        output req_ready, resp_valid, resp_ct, resp_timeout, busy, cmd, din
    );

    modport slave (
        output req_valid, req_pt, req_key, req_load_key, c_ok, c_ready, c_dout,
        input  req_ready, resp_valid, resp_ct, resp_timeout, busy, cmd, din
    );

endinterface

// File: rtl/aes_byte_shifter.sv
// 128-bit block register: parallel load, byte shift-out at the LSB end, byte shift-in at the MSB.
module aes_byte_shifter (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [127:0] load_data_i,
    input  logic         shift_out_i,
    input  logic         shift_in_i,
    input  logic [7:0]   byte_i,
    output logic [7:0]   byte_o,
    output logic [127:0] data_next_o
);

    logic [127:0] data_d, data_q;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_in_i) begin
            data_d = {byte_i, data_q[127:8]};
        end else if (shift_out_i) begin
            data_d = {8'h00, data_q[127:8]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign byte_o      = data_q[7:0];
    assign data_next_o = data_d;

endmodule

// File: rtl/aes_cmd_driver.sv
// Host-side master: serialises plaintext/key into SP/SK/ST commands and reassembles ciphertext.
module aes_cmd_driver
    import aes_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned ST_CYC      = 2
) (
    input  logic             clk,
    input  logic             rst_,
    aes_cmd_driver_if.master drv_if
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [3:0]  LastByte = 4'(BYTES_PER_BLOCK - 1);

    state_e         state_q;
    logic [3:0]     byte_cnt_q;
    logic [7:0]     ph_cnt_q;
    logic [TW-1:0]  tmo_cnt_q;
    logic [127:0]   key_q;
    logic           load_key_q;
    logic [1:0]     cmd_q;
    logic [7:0]     din_q;
    logic           busy_q;
    logic           resp_valid_q;
    logic [127:0]   resp_ct_q;
    logic           resp_timeout_q;

    logic           accept;
    logic           tx_load, tx_shift, rx_shift;
    logic [127:0]   tx_load_val;
    logic [7:0]     tx_byte;
    logic [127:0]   rx_next;
    logic [7:0]     unused_rx_byte;
    logic [127:0]   unused_tx_next;

    assign drv_if.req_ready = (state_q == StIdle) & drv_if.c_ready;
    assign accept           = drv_if.req_ready & drv_if.req_valid;

    // Plaintext loads on accept; the key replaces it once the SP phase has drained.
    assign tx_load     = accept | ((state_q == StGap1) & (ph_cnt_q == 8'(GAP_CYC - 1)) & load_key_q);
    assign tx_load_val = (state_q == StIdle) ? drv_if.req_pt : key_q;
    assign tx_shift    = (state_q == StSpHdr) | (state_q == StSpData) |
                         (state_q == StSkHdr) | (state_q == StSkData);
    assign rx_shift    = ((state_q == StWaitOk) & drv_if.c_ok) | (state_q == StCapture);

    aes_byte_shifter u_tx_shifter (
        .clk_i       (clk),
        .rst_ni      (rst_),
        .load_i      (tx_load),
        .load_data_i (tx_load_val),
        .shift_out_i (tx_shift),
        .shift_in_i  (1'b0),
        .byte_i      (8'h00),
        .byte_o      (tx_byte),
        .data_next_o (unused_tx_next)
    );

    aes_byte_shifter u_rx_shifter (
        .clk_i       (clk),
        .rst_ni      (rst_),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_out_i (1'b0),
        .shift_in_i  (rx_shift),
        .byte_i      (drv_if.c_dout),
        .byte_o      (unused_rx_byte),
        .data_next_o (rx_next)
    );

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q        <= StIdle;
            byte_cnt_q     <= '0;
            ph_cnt_q       <= '0;
            tmo_cnt_q      <= '0;
            key_q          <= '0;
            load_key_q     <= 1'b0;
            cmd_q          <= CMD_ID;
            din_q          <= 8'h00;
            busy_q         <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_ct_q      <= '0;
            resp_timeout_q <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: if (accept) begin
                    state_q    <= StSpHdr;
                    cmd_q      <= CMD_SP;
                    din_q      <= 8'h00;
                    busy_q     <= 1'b1;
                    key_q      <= drv_if.req_key;
                    load_key_q <= drv_if.req_load_key;
                end
                StSpHdr: begin
                    state_q <= StSpData;
                    din_q   <= tx_byte;
                end
                StSpData: if (byte_cnt_q == LastByte) begin
                    byte_cnt_q <= '0;
                    state_q    <= StGap1;
                    cmd_q      <= CMD_ID;
                    din_q      <= 8'h00;
                end else begin
                    byte_cnt_q <= byte_cnt_q + 4'd1;
                    din_q      <= tx_byte;
                end
                StGap1: if (ph_cnt_q == 8'(GAP_CYC - 1)) begin
                    ph_cnt_q <= '0;
                    state_q  <= load_key_q ? StSkHdr : StSt;
                    cmd_q    <= load_key_q ? CMD_SK : CMD_ST;
                end else begin
                    ph_cnt_q <= ph_cnt_q + 8'd1;
                end
                StSkHdr: begin
                    state_q <= StSkData;
                    din_q   <= tx_byte;
                end
                StSkData: if (byte_cnt_q == LastByte) begin
                    byte_cnt_q <= '0;
                    state_q    <= StGap2;
                    cmd_q      <= CMD_ID;
                    din_q      <= 8'h00;
                end else begin
                    byte_cnt_q <= byte_cnt_q + 4'd1;
                    din_q      <= tx_byte;
                end
                StGap2: if (ph_cnt_q == 8'(GAP_CYC - 1)) begin
                    ph_cnt_q <= '0;
                    state_q  <= StSt;
                    cmd_q    <= CMD_ST;
                end else begin
                    ph_cnt_q <= ph_cnt_q + 8'd1;
                end
                StSt: if (ph_cnt_q == 8'(ST_CYC - 1)) begin
                    ph_cnt_q  <= '0;
                    tmo_cnt_q <= '0;
                    state_q   <= StWaitOk;
                    cmd_q     <= CMD_ID;
                    din_q     <= 8'h00;
                end else begin
                    ph_cnt_q <= ph_cnt_q + 8'd1;
                end
                // ok wins over the timeout on the final cycle
                StWaitOk: if (drv_if.c_ok) begin
                    tmo_cnt_q  <= '0;
                    byte_cnt_q <= 4'd1;
                    state_q    <= StCapture;
                end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                    tmo_cnt_q      <= '0;
                    state_q        <= StResp;
                    busy_q         <= 1'b0;
                    resp_valid_q   <= 1'b1;
                    resp_ct_q      <= '0;
                    resp_timeout_q <= 1'b1;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                end
                StCapture: if (byte_cnt_q == LastByte) begin
                    byte_cnt_q     <= '0;
                    state_q        <= StResp;
                    busy_q         <= 1'b0;
                    resp_valid_q   <= 1'b1;
                    resp_ct_q      <= rx_next;
                    resp_timeout_q <= 1'b0;
                end else begin
                    byte_cnt_q <= byte_cnt_q + 4'd1;
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign drv_if.cmd          = cmd_q;
    assign drv_if.din          = din_q;
    assign drv_if.busy         = busy_q;
    assign drv_if.resp_valid   = resp_valid_q;
    assign drv_if.resp_ct      = resp_ct_q;
    assign drv_if.resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_aes_cmd_driver.sv
// Directed bench for aes_cmd_driver with an inline cycle-by-cycle cipher model.
module tb_aes_cmd_driver;
    import aes_cmd_pkg::*;

    localparam int unsigned TMO = 64;

    logic clk = 1'b0;
    logic rst_ = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    aes_cmd_driver_if bus ();

    aes_cmd_driver #(
        .TIMEOUT_CYC (TMO),
        .GAP_CYC     (2),
        .ST_CYC      (2)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .drv_if (bus)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds c_ready low for 'stall' cycles with the request pending, then lets it through.
    task automatic do_accept(input logic [127:0] pt, input logic [127:0] key, input logic lk,
                             input int stall);
        bus.req_pt       = pt;
        bus.req_key      = key;
        bus.req_load_key = lk;
        bus.req_valid    = 1'b1;
        bus.c_ready      = 1'b0;
        #1;
        for (int i = 0; i < stall; i++) begin
            check_eq("hs_ready_low", bus.req_ready, 1'b0);
            check_eq("hs_cmd_idle", bus.cmd, CMD_ID);
            tick;
        end
        bus.c_ready = 1'b1;
        #1;
        check_eq("hs_ready", bus.req_ready, 1'b1);
        tick;
        bus.req_valid = 1'b0;
    endtask

    // okd < 0: the cipher never answers. stray: command-phase cycle that carries a spurious ok.
    task automatic run_txn(input logic [127:0] pt, input logic [127:0] key, input logic lk,
                           input logic [127:0] ct, input int okd, input int stall,
                           input int stray);
        logic [9:0]   seq[$];
        logic [127:0] exp_ct;
        int           n;
        seq = {};
        seq.push_back({CMD_SP, 8'h00});
        for (int k = 0; k < 16; k++) seq.push_back({CMD_SP, pt[8*k +: 8]});
        repeat (2) seq.push_back({CMD_ID, 8'h00});
        if (lk) begin
            seq.push_back({CMD_SK, 8'h00});
            for (int k = 0; k < 16; k++) seq.push_back({CMD_SK, key[8*k +: 8]});
            repeat (2) seq.push_back({CMD_ID, 8'h00});
        end
        repeat (2) seq.push_back({CMD_ST, 8'h00});

        do_accept(pt, key, lk, stall);
        check_eq("busy_hi", bus.busy, 1'b1);
        for (int i = 0; i < seq.size(); i++) begin
            check_eq("seq", {bus.cmd, bus.din}, seq[i]);
            bus.c_ok   = (i == stray);
            bus.c_dout = 8'hee;
            tick;
        end
        bus.c_ok = 1'b0;
        check_eq("wait_cmd", bus.cmd, CMD_ID);

        if (okd < 0) begin
            n = 0;
            while (!bus.resp_valid && n < TMO + 8) begin
                tick;
                n++;
            end
            exp_ct = '0;
            check_eq("tmo_lat", n, TMO);
            check_eq("tmo_flag", bus.resp_timeout, 1'b1);
        end else begin
            repeat (okd) tick;
            bus.c_ok   = 1'b1;
            bus.c_dout = ct[7:0];
            tick;
            for (int k = 1; k < 16; k++) begin
                if (k == 15) check_eq("resp_early", bus.resp_valid, 1'b0);
                bus.c_ok   = (k == 8);
                bus.c_dout = ct[8*k +: 8];
                tick;
            end
            bus.c_ok = 1'b0;
            exp_ct   = ct;
            // ok cycle counted as the first of 17: resp_valid lands on the 17th
            check_eq("resp_valid", bus.resp_valid, 1'b1);
            check_eq("resp_tmo0", bus.resp_timeout, 1'b0);
        end
        check_eq("resp_ct", bus.resp_ct, exp_ct);
        check_eq("busy_lo", bus.busy, 1'b0);
        tick;
        check_eq("resp_pulse", bus.resp_valid, 1'b0);
        check_eq("resp_hold", bus.resp_ct, exp_ct);
        bus.c_ok = 1'b1;
        tick;
        bus.c_ok = 1'b0;
        check_eq("idle_ok_cmd", bus.cmd, CMD_ID);
        check_eq("idle_ok_busy", bus.busy, 1'b0);
        check_eq("idle_ok_resp", bus.resp_valid, 1'b0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] pt, key, ct;
        logic         seen;
        int           len;
        bus.req_valid    = 1'b0;
        bus.req_pt       = '0;
        bus.req_key      = '0;
        bus.req_load_key = 1'b0;
        bus.c_ok         = 1'b0;
        bus.c_ready      = 1'b0;
        bus.c_dout       = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cmd", bus.cmd, CMD_ID);
        check_eq("rst_din", bus.din, 8'h00);
        check_eq("rst_ready", bus.req_ready, 1'b0);
        check_eq("rst_rv", bus.resp_valid, 1'b0);
        check_eq("rst_ct", bus.resp_ct, 128'h0);
        check_eq("rst_tmo", bus.resp_timeout, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        rst_ = 1'b1;
        tick;

        // Full load with key, ok 20 cycles into WAIT_OK
        run_txn(128'h00041214120412000c00131108231919, 128'h2475a2b33475568831e2120013aa5487,
                1'b1, 128'hc81677bc9b7ac93b25027992b0261996, 20, 0, -1);
        // Key reuse
        run_txn(128'h00112233445566778899aabbccddeeff, 128'h0, 1'b0,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, 0, -1);
        // Timeout, then ok on the final timeout cycle
        run_txn(128'h0123456789abcdef0123456789abcdef, 128'h55, 1'b1, 128'h0, -1, 0, -1);
        run_txn(128'hfedcba9876543210fedcba9876543210, 128'h0, 1'b0,
                128'h0f0e0d0c0b0a09080706050403020100, TMO - 1, 0, -1);
        // Handshake stall with c_ready low
        run_txn(128'h1, 128'h2, 1'b1, 128'h3, 0, 4, -1);

        // Reset in the middle of SK_DATA
        bus.req_pt       = 128'hffeeddccbbaa99887766554433221100;
        bus.req_key      = 128'h0f0e0d0c0b0a09080706050403020100;
        bus.req_load_key = 1'b1;
        bus.req_valid    = 1'b1;
        bus.c_ready      = 1'b1;
        tick;
        bus.req_valid = 1'b0;
        repeat (1 + 16 + 2 + 1 + 5) tick;
        check_eq("rst_pre_sk", {bus.cmd, bus.din}, {CMD_SK, 8'h05});
        bus.c_ready = 1'b0;
        rst_        = 1'b0;
        tick;
        check_eq("mid_rst_cmd", bus.cmd, CMD_ID);
        check_eq("mid_rst_din", bus.din, 8'h00);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_rv", bus.resp_valid, 1'b0);
        rst_ = 1'b1;
        bus.c_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.resp_valid || bus.cmd != CMD_ID) seen = 1'b1;
            tick;
        end
        check_eq("post_rst_quiet", seen, 1'b0);

        // Back-to-back random traffic with stray ok pulses
        for (int t = 0; t < 20; t++) begin
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            ct  = {$urandom, $urandom, $urandom, $urandom};
            len = (t % 2 == 0) ? 39 : 22;
            run_txn(pt, key, (t % 2 == 0), ct, int'($urandom_range(0, 40)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, len - 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_cmd_driver.md
Name: aes_cmd_driver

Overview:
Host-side master for the aescipher byte-serial command interface (cmd/din in, ok/ready/dout out). Accepts one 128-bit plaintext and an optional 128-bit key through a valid/ready request port. Serialises them into the SP/SK/ST command sequence, waits for ok, and reassembles the 16-byte ciphertext from dout. It replaces hand-written bench stimulus and is the block the SoC wrapper uses to drive the cipher.

Parameters:
TIMEOUT_CYC, 4096, maximum cycles in WAIT_OK before the request is aborted with timeout.
GAP_CYC, 2, number of CMD_ID cycles inserted between command phases.
ST_CYC, 2, number of cycles CMD_ST is held.

Ports:
clk  in  1  clock, rising edge
rst_  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  driver accepts request this cycle
req_pt  in  128  plaintext, byte 0 = bits 7:0
req_key  in  128  key, byte 0 = bits 7:0
req_load_key  in  1  1 = send key phase; 0 = reuse the key already loaded in the cipher
resp_valid  out  1  one-cycle pulse, response fields valid
resp_ct  out  128  ciphertext, byte 0 = bits 7:0
resp_timeout  out  1  qualifies resp_valid: ok never arrived
busy  out  1  high from accept until resp_valid
cmd  out  2  command to cipher (ID=00, ST=01, SK=10, SP=11)
din  out  8  data byte to cipher
c_ok  in  1  cipher completion pulse
c_ready  in  1  cipher idle/ready
c_dout  in  8  cipher output byte

Behaviour:
- Reset values: cmd=ID, din=0, req_ready=0, resp_valid=0, resp_ct=0, resp_timeout=0, busy=0. State=IDLE; all counters 0.
- Reset asserted mid-operation aborts immediately. No response is issued.
- req_ready = (state==IDLE) & c_ready. A request is accepted on a cycle where req_valid & req_ready. req_pt, req_key and req_load_key are latched on acceptance.
- States and transitions:
  - IDLE: cmd=ID. Goes to SP_HDR on accept.
  - SP_HDR: 1 cycle, cmd=SP, din=0.
  - SP_DATA: 16 cycles, cmd=SP, din=pt byte k for k=0..15, LSB byte first.
  - GAP1: GAP_CYC cycles, cmd=ID. Then goes to SK_HDR if load_key, else to ST.
  - SK_HDR: 1 cycle, cmd=SK.
  - SK_DATA: 16 cycles, cmd=SK, key bytes in LSB-first order.
  - GAP2: GAP_CYC cycles, cmd=ID.
  - ST: ST_CYC cycles, cmd=ST.
  - WAIT_OK: cmd=ID. The timeout counter counts from 0.
    - If c_ok=1, go to CAPTURE and take byte 0 from c_dout in the same cycle.
    - If the counter reaches TIMEOUT_CYC-1 without c_ok, go to RESP with timeout=1.
  - CAPTURE: 15 further cycles capturing bytes 1..15 of c_dout, one per cycle.
  - RESP: 1 cycle. resp_valid=1, resp_ct holds the assembled bytes. On timeout resp_ct=0. Then goes to IDLE.
- din=0 whenever cmd is ID or ST.
- Cipher protocol (fixed): ok is a 1-cycle pulse. dout carries ciphertext byte k on the k-th cycle counting from the ok cycle, k=0..15.
- c_ok outside WAIT_OK is ignored.
- c_ok on the final timeout cycle counts as success.
- resp_ct and resp_timeout hold their values until the next RESP. Only resp_valid pulses.
- Byte counter is 4 bits and wraps 15→0 at each phase exit.
- Timeout counter width is clog2(TIMEOUT_CYC).
- End-to-end latency:
  - With key: 1+16+GAP+1+16+GAP+ST_CYC, then the wait for ok, then 16 capture cycles, then 1 RESP cycle.
  - Without key: 1+16+GAP+ST_CYC, then the wait for ok, then 16 capture cycles, then 1 RESP cycle.
- No back-pressure on resp: the consumer must sample on the pulse.

Decomposition:
- Package aes_cmd_pkg contains:
  - the CMD_ID/ST/SK/SP 2-bit constants;
  - the state enum;
  - the BYTES_PER_BLOCK=16 constant.
- Sub-module aes_byte_shifter: a 128-bit register with load, shift-out (8-bit LSB port) and shift-in (8-bit into the MSB end, shifting right). It is instantiated twice: once for outgoing pt/key and once for incoming ct.

Test Plan:
1. Reset check: pulse rst_ low mid-SK_DATA → next cycle cmd=ID, busy=0, no resp_valid. Also check reset values on power-up.
2. Full load: pt=00041214120412000c00131108231919, key=2475a2b33475568831e2120013aa5487, load_key=1, model asserts ok 20 cycles after ST. Required response:
   - din sequence 19,19,23,08,...,00 under SP;
   - then 87,54,aa,13,... under SK;
   - ST held 2 cycles;
   - resp_ct equals the 16 bytes driven on c_dout;
   - resp_valid exactly 17 cycles after the ok cycle.
3. Key reuse: load_key=0 → no SK cycles appear; ST follows GAP1 directly.
4. Timeout: TIMEOUT_CYC=64, model never asserts ok → resp_valid with resp_timeout=1 and resp_ct=0, 64 cycles after entering WAIT_OK.
5. Handshake: req_valid held with c_ready=0 → req_ready=0 and no cmd activity. c_ready rises → accept in that cycle, SP_HDR next.
6. Back-to-back: 20 requests with random pt/key, ok pulses before and after WAIT_OK → only in-window ok is honoured; 20 correct responses.
